// File: rtl/pipelined_instr_encoder.sv
// pipelined_instr_encoder: decodes 32-bit ARM instruction words into a
// control-unit state number and class code, queued in a DEPTH-entry FIFO
// with valid/ready on both sides and a synchronous flush.
// Optional build macro: ENCODER_COND_EN (evaluate cond field against flags).
module pipelined_instr_encoder #(
  parameter int STATE_W     = 10,
  parameter int DEPTH       = 2,
  parameter int FETCH_STATE = 1,
  parameter int LS_IMM_BASE = 20,
  parameter int LS_REG_BASE = 52,
  parameter int MISC_BASE   = 84,
  parameter int DP_BASE     = 116,
  parameter int BR_BASE     = 148
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instruction,
  input  logic [3:0]         flags,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] state_number,
  output logic [2:0]         instr_class
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [STATE_W-1:0] state;
    logic [2:0]         cls;
  } entry_t;

  entry_t          dec;
  logic            cond_pass;
  logic [2:0]      op;
  logic [1:0]      mode;
  logic [4:0]      ls_idx;
  logic [4:0]      misc_idx;
  logic [4:0]      dp_idx;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;

  // Bits of the word that never steer the decode.
  logic unused_sink;
  assign unused_sink = ^{instruction, flags};

`ifdef ENCODER_COND_EN
  logic fn, fz, fc, fv;
  assign {fn, fz, fc, fv} = flags;

  // Standard ARM condition table; 4'b1111 is handled as unknown by the decoder.
  always_comb begin
    cond_pass = 1'b1;
    case (instruction[31:28])
      4'h0: cond_pass = fz;
      4'h1: cond_pass = !fz;
      4'h2: cond_pass = fc;
      4'h3: cond_pass = !fc;
      4'h4: cond_pass = fn;
      4'h5: cond_pass = !fn;
      4'h6: cond_pass = fv;
      4'h7: cond_pass = !fv;
      4'h8: cond_pass = fc & !fz;
      4'h9: cond_pass = !fc | fz;
      4'hA: cond_pass = (fn == fv);
      4'hB: cond_pass = (fn != fv);
      4'hC: cond_pass = !fz & (fn == fv);
      4'hD: cond_pass = fz | (fn != fv);
      default: cond_pass = 1'b1;
    endcase
  end
`else
  assign cond_pass = 1'b1;
`endif

  // Instruction decode, first matching rule wins; failed/unknown -> fetch.
  always_comb begin
    op       = instruction[27:25];
    // P=1: offset (W=0) or pre-indexed (W=1); P=0: post-indexed.
    mode     = instruction[24] ? {1'b0, instruction[21]} : 2'd2;
    ls_idx   = {instruction[20], instruction[22], instruction[23], mode};
    misc_idx = {instruction[20], instruction[22], instruction[23], mode};
    dp_idx   = {instruction[24:21], instruction[20]};
    dec.state = STATE_W'(FETCH_STATE);
    dec.cls   = 3'd0;
    if (instruction[31:28] == 4'b1111 || !cond_pass) begin
      dec.state = STATE_W'(FETCH_STATE);
      dec.cls   = 3'd0;
    end else if (op == 3'b010) begin
      dec.state = STATE_W'(32'(LS_IMM_BASE) + 32'(ls_idx));
      dec.cls   = 3'd1;
    end else if (op == 3'b011 && !instruction[4]) begin
      dec.state = STATE_W'(32'(LS_REG_BASE) + 32'(ls_idx));
      dec.cls   = 3'd2;
    end else if (op == 3'b000 && instruction[7] && instruction[4]) begin
      dec.state = STATE_W'(32'(MISC_BASE) + 32'(misc_idx));
      dec.cls   = 3'd3;
    end else if (op == 3'b000 || op == 3'b001) begin
      dec.state = STATE_W'(32'(DP_BASE) + 32'(dp_idx));
      dec.cls   = 3'd4;
    end else if (op == 3'b101) begin
      dec.state = STATE_W'(32'(BR_BASE) + 32'(instruction[24]));
      dec.cls   = 3'd5;
    end
  end

  // A full FIFO refuses input even if the head is popped this cycle.
  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head is forced to zero while empty so reset/flush present a clean output.
  assign state_number = out_valid ? mem_q[rd_ptr_q].state : '0;
  assign instr_class  = out_valid ? mem_q[rd_ptr_q].cls   : '0;

  // FIFO next state; flush overrides both push and pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dec;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_pipelined_instr_encoder.sv
// Self-checking bench for pipelined_instr_encoder: directed vector table,
// hand-written backpressure/flush/reset sequences, then randomized traffic
// checked against a queue-based reference model.
module tb_pipelined_instr_encoder;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instruction = '0;
  logic [3:0]  flags = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [9:0]  state_number;
  logic [2:0]  instr_class;

  int n_cmp = 0;
  int n_err = 0;

  pipelined_instr_encoder dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .flags(flags), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .state_number(state_number), .instr_class(instr_class)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  flg;
    int          st;
    int          cl;
  } vec_t;

  typedef struct {
    int st;
    int cl;
  } exp_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ARM condition check: pairs of codes share a test, odd code inverts it.
  function automatic bit ref_cond(input int c, input logic [3:0] f);
    bit n, z, cf, v, r;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
`ifdef ENCODER_COND_EN
    case (c / 2)
      0: r = z;
      1: r = cf;
      2: r = n;
      3: r = v;
      4: r = cf && !z;
      5: r = (n == v);
      6: r = !z && (n == v);
      default: r = 1;
    endcase
    if (c < 14 && (c % 2) == 1) r = !r;
`else
    r = 1;
`endif
    return r;
  endfunction

  // Reference decode from the rule list using plain integer arithmetic.
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [3:0] f);
    exp_t e;
    int op, m, ls;
    op = int'(w[27:25]);
    m  = (w[24] == 1'b0) ? 2 : int'(w[21]);
    ls = int'(w[20]) * 16 + int'(w[22]) * 8 + int'(w[23]) * 4 + m;
    e.st = 1; e.cl = 0;
    if (w[31:28] == 4'hF || !ref_cond(int'(w[31:28]), f)) begin
      e.st = 1; e.cl = 0;
    end else if (op == 2) begin
      e.st = 20 + ls; e.cl = 1;
    end else if (op == 3 && w[4] == 1'b0) begin
      e.st = 52 + ls; e.cl = 2;
    end else if (op == 0 && w[7] && w[4]) begin
      e.st = 84 + ls; e.cl = 3;
    end else if (op == 0 || op == 1) begin
      e.st = 116 + int'(w[24:21]) * 2 + int'(w[20]); e.cl = 4;
    end else if (op == 5) begin
      e.st = 148 + int'(w[24]); e.cl = 5;
    end
    e.st = e.st % 1024;
    return e;
  endfunction

  vec_t vt[$];
  exp_t mq[$];

  initial begin
    // Directed table: {instruction, flags, expected state, expected class}
    vt.push_back('{32'hE5812004, 4'h0, 24,  1});
    vt.push_back('{32'hE5D12004, 4'h0, 48,  1});
    vt.push_back('{32'hE4912004, 4'h0, 42,  1});
    vt.push_back('{32'hE5A12004, 4'h0, 25,  1});
    vt.push_back('{32'hE7912003, 4'h0, 72,  2});
    vt.push_back('{32'hE1D120B4, 4'h0, 112, 3});
    vt.push_back('{32'hE0912003, 4'h0, 125, 4});
    vt.push_back('{32'hE3A00001, 4'h0, 142, 4});
    vt.push_back('{32'hEB000010, 4'h0, 149, 5});
    vt.push_back('{32'hE7F000F0, 4'h0, 1,   0});
    vt.push_back('{32'hF5812004, 4'h0, 1,   0});
    vt.push_back('{32'h0A000000, 4'h4, 148, 5});
`ifdef ENCODER_COND_EN
    vt.push_back('{32'h0A000000, 4'h0, 1,   0});
`else
    vt.push_back('{32'h0A000000, 4'h0, 148, 5});
`endif

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_state", 32'(state_number), 0);
    chk("rst_class", 32'(instr_class), 0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc();

    // Directed vectors, one at a time: 1-cycle latency, then pop
    foreach (vt[i]) begin
      chk("vec_idle", 32'(out_valid), 0);
      in_valid = 1'b1; instruction = vt[i].instr; flags = vt[i].flg;
      cyc();
      in_valid = 1'b0;
      chk("vec_valid", 32'(out_valid), 1);
      chk("vec_state", 32'(state_number), 32'(vt[i].st));
      chk("vec_class", 32'(instr_class), 32'(vt[i].cl));
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      chk("vec_popped", 32'(out_valid), 0);
    end

    // Backpressure: third word waits for a pop, order preserved
    flags = 4'hE;
    in_valid = 1'b1; instruction = 32'hE5812004;
    cyc();
    chk("bp_ready1", 32'(in_ready), 1);
    instruction = 32'hE0912003;
    cyc();
    chk("bp_full", 32'(in_ready), 0);
    instruction = 32'hEB000010;
    cyc();
    chk("bp_still_full", 32'(in_ready), 0);
    chk("bp_head_stable", 32'(state_number), 24);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("bp_after_pop_ready", 32'(in_ready), 1);
    chk("bp_head2", 32'(state_number), 125);
    cyc();
    in_valid = 1'b0;
    chk("bp_refull", 32'(in_ready), 0);
    out_ready = 1'b1;
    chk("bp_order_b", 32'(state_number), 125);
    cyc();
    chk("bp_order_c", 32'(state_number), 149);
    cyc();
    chk("bp_drained", 32'(out_valid), 0);
    out_ready = 1'b0;

    // Flush with a same-cycle push at count=1
    in_valid = 1'b1; instruction = 32'hE5812004;
    cyc();
    instruction = 32'hEB000010; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 32'(out_valid), 0);
    chk("fl_in_ready", 32'(in_ready), 1);
    chk("fl_state", 32'(state_number), 0);
    cyc();
    chk("fl_push_dropped", 32'(out_valid), 0);

    // Asynchronous reset mid-stream with 2 entries queued
    in_valid = 1'b1; instruction = 32'hE5D12004;
    cyc();
    cyc();
    in_valid = 1'b0;
    chk("mr_full", 32'(in_ready), 0);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_out_valid", 32'(out_valid), 0);
    chk("mr_in_ready", 32'(in_ready), 1);
    chk("mr_state", 32'(state_number), 0);
    chk("mr_class", 32'(instr_class), 0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc();

    // Randomized traffic against the queue model
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] w;
      bit do_push, do_pop, do_flush;
      exp_t e;
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[31:28] = 4'hE;
      instruction = w;
      flags       = 4'($urandom);
      in_valid    = ($urandom_range(0, 2) != 0);
      out_ready   = ($urandom_range(0, 1) != 0);
      flush       = ($urandom_range(0, 19) == 0);
      #3;
      chk("rnd_in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      chk("rnd_out_valid", 32'(out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("rnd_state", 32'(state_number), 32'(mq[0].st));
        chk("rnd_class", 32'(instr_class), 32'(mq[0].cl));
      end
      do_flush = flush;
      do_push  = in_valid && (mq.size() < DEPTH);
      do_pop   = (mq.size() > 0) && out_ready;
      e = ref_decode(w, flags);
      @(posedge clk);
      if (do_flush) mq.delete();
      else begin
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(e);
      end
      #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
